// File: rtl/vartheta_inv_serial.sv
// Inverse SWAN vartheta: rotates columns 0/1/2 left by PC/PB/PA bits, column 3 untouched.
// Bit-serial: each ROT cycle moves every unfinished column by one bit.
module vartheta_inv_serial #(
  parameter int BLOCK_SIZE  = 64,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int PA          = 1,
  parameter int PB          = 2,
  parameter int PC          = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y,
  output logic                 busy
);

  localparam int MAXP  = (PA > PB) ? ((PA > PC) ? PA : PC) : ((PB > PC) ? PB : PC);
  localparam int CNT_W = $clog2(COLUMN_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [0:SIDE_SIZE-1]   data_reg;
  logic [0:SIDE_SIZE-1]   data_rot;

  // One-bit left rotate for each column still short of its rotate amount.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    localparam int PK = (gi == 0) ? PC : (gi == 1) ? PB : (gi == 2) ? PA : 0;
    localparam int B  = gi * COLUMN_SIZE;
    if (PK > 0) begin : g_rot
      assign data_rot[B +: COLUMN_SIZE] = (cnt_reg < CNT_W'(PK))
          ? {data_reg[B+1 +: COLUMN_SIZE-1], data_reg[B]}
          : data_reg[B +: COLUMN_SIZE];
    end else begin : g_hold
      assign data_rot[B +: COLUMN_SIZE] = data_reg[B +: COLUMN_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg  <= x;
            cnt_reg   <= '0;
            state_reg <= (MAXP == 0) ? DONE : ROT;
          end
        end
        ROT: begin
          data_reg <= data_rot;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(MAXP - 1)) state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign y         = data_reg;

endmodule

// File: tb/tb_vartheta_inv_serial.sv
// Bench for vartheta_inv_serial: directed vector table, round trip against a
// forward vartheta model, back-pressure, mid-rotate reset, ignored input, zero-rotate build.
module tb_vartheta_inv_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:31] x, y;
  logic        in_valid_z, in_ready_z, out_valid_z, out_ready_z, busy_z;
  logic [0:31] x_z, y_z;

  int n_checks = 0;
  int n_pass   = 0;

  vartheta_inv_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  vartheta_inv_serial #(.PA(0), .PB(0), .PC(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_z), .in_ready(in_ready_z), .x(x_z),
    .out_valid(out_valid_z), .out_ready(out_ready_z), .y(y_z), .busy(busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Column rotate model; left=1 is the inverse (DUT function), left=0 is forward vartheta.
  function automatic logic [31:0] rot_cols(input logic [31:0] v, input bit left);
    logic [31:0] r;
    logic [7:0]  c;
    logic [15:0] t;
    int          p;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      c = v[31-8*k -: 8];
      p = (k == 0) ? 7 : (k == 1) ? 2 : (k == 2) ? 1 : 0;
      t = {c, c};
      if (left) begin
        t = t << p;
        r[31-8*k -: 8] = t[15:8];
      end else begin
        t = t >> p;
        r[31-8*k -: 8] = t[7:0];
      end
    end
    return r;
  endfunction

  // Send one block with out_ready=1; lat counts edges from the accepting edge inclusive.
  task automatic xfer(input logic [31:0] v, output logic [31:0] r, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    x = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x = $urandom();
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r = y;
    $display("xfer x=%h y=%h latency=%0d", v, r, lat);
  endtask

  typedef struct {
    logic [31:0] xv;
    logic [31:0] yv;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] r, v, y0;
  int          lat;

  initial begin
    vecs[0] = '{32'h80808080, 32'h40020180};
    vecs[1] = '{32'h01010101, 32'h80040201};
    vecs[2] = '{32'h00000000, 32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{32'h12345678, 32'h09D0AC78};
    vecs[5] = '{32'hA5C3F00F, 32'hD20FE10F};

    rst_n = 1'b0;
    in_valid = 1'b0; x = '0; out_ready = 1'b1;
    in_valid_z = 1'b0; x_z = '0; out_ready_z = 1'b1;

    // Reset state
    #3;
    check("reset_outputs", {y, out_valid, busy, in_ready}, {32'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].xv, r, lat);
      check($sformatf("vec%0d_y", i), r, vecs[i].yv);
      check($sformatf("vec%0d_latency", i), lat, 8);
      if (i == 0) begin
        @(negedge clk);
        check("pulse_one_cycle", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
      end
    end

    // Round trip through the forward model
    for (int i = 0; i < 1000; i++) begin
      v = $urandom();
      xfer(rot_cols(v, 1'b0), r, lat);
      check("roundtrip", r, v);
    end

    // Back-pressure in DONE
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 8);
    y0 = y;
    check("bp_y", y0, 32'h09D0AC78);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {y, out_valid, in_ready, busy}, {y0, 1'b1, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
    $display("backpressure y=%h held 20 cycles", y0);

    // Reset pulse mid-rotate (cnt==3)
    in_valid = 1'b1;
    x = 32'h80808080;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrot_reset", {y, out_valid, busy, in_ready}, {32'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    xfer(32'h01010101, r, lat);
    check("post_reset_y", r, 32'h80040201);
    check("post_reset_latency", lat, 8);

    // in_valid held with changing x during ROT/DONE
    @(negedge clk);
    in_valid = 1'b1;
    x = 32'hA5C3F00F;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      x = $urandom();
      if (!out_valid) check("ignore_in_ready", in_ready, 1'b0);
    end while (!out_valid && lat < 50);
    check("ignore_y", y, 32'hD20FE10F);
    check("ignore_latency", lat, 8);
    check("ignore_done_ready", in_ready, 1'b0);
    x = 32'h12345678;
    @(negedge clk);
    check("reaccept_idle", {in_ready, busy}, {1'b1, 1'b0});
    @(negedge clk);
    check("reaccept_taken", {in_ready, busy}, {1'b0, 1'b1});
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("reaccept_y", y, 32'h09D0AC78);
    check("reaccept_latency", lat, 8);
    $display("ignore-input y=%h then y=%h", 32'hD20FE10F, y);

    // Zero-rotate build: identity, result on the accepting edge
    @(negedge clk);
    in_valid_z = 1'b1;
    x_z = 32'h80808080;
    @(posedge clk);
    @(negedge clk);
    in_valid_z = 1'b0;
    x_z = 32'h0;
    check("zero_valid", {out_valid_z, busy_z, in_ready_z}, {1'b1, 1'b1, 1'b0});
    check("zero_y", y_z, 32'h80808080);
    @(negedge clk);
    check("zero_pulse", {out_valid_z, in_ready_z}, {1'b0, 1'b1});
    $display("zero-rotate x=80808080 y=%h", y_z);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
